wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter NUM_SRC, default 3, number of writeback producers (ALU, MEM, long-latency unit); legal range 2..8.
REQ-003 SHALL have parameter RADDR_W, default 5, register index width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 src_valid  in  NUM_SRC  per-source result valid.
REQ-007 src_ready  out  NUM_SRC  per-source accept; a transfer occurs when valid and ready are both high at a rising edge.
REQ-008 src_data  in  NUM_SRC*DATA_WIDTH  packed results; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 src_rd  in  NUM_SRC*RADDR_W  packed destination indices, packed like src_data.
REQ-010 src_we  in  NUM_SRC  per-source regwrite intent from the controller.
REQ-011 flush  in  1  synchronous kill from trap unit.
REQ-012 rf_we  out  1  registered regfile write enable.
REQ-013 rf_waddr  out  RADDR_W  registered write index.
REQ-014 rf_wdata  out  DATA_WIDTH  registered write data.
REQ-015 pend_valid  out  NUM_SRC  holding buffer i occupied.
REQ-016 pend_rd  out  NUM_SRC*RADDR_W  rd held in buffer i, for the hazard unit.

Function
REQ-017 Each source SHALL own one holding entry {data, rd, we}; src_ready[i] = entry empty OR entry granted this cycle, and flush low.
REQ-018 Among occupied entries, one grant per cycle SHALL be issued, round-robin: search starts at ptr, wraps mod NUM_SRC; after a grant to i, ptr <= (i+1) mod NUM_SRC; no grant leaves ptr unchanged.
REQ-019 A granted entry SHALL be released that cycle; rf_we/rf_waddr/rf_wdata SHALL load from it on the same edge.
REQ-020 rf_we SHALL be 1 only if an entry was granted, its we = 1, its rd != 0, and flush was low; otherwise 0.
REQ-021 When rf_we = 0, rf_waddr and rf_wdata SHALL hold their previous values.
REQ-022 Uncontested latency SHALL be 2 cycles: transfer at edge E, rf_we high after edge E+1.
REQ-023 Release and new fill of the same entry at one edge SHALL both take effect, giving 1 transfer/cycle per source with no bubble.
REQ-024 flush high at an edge SHALL clear all entries, refuse all transfers, force rf_we to 0, and leave ptr unchanged.
REQ-025 Entries with rd = 0 or we = 0 SHALL be granted and consumed normally and produce no write.
REQ-026 The block SHALL NOT reorder writes to the same rd within one source; cross-source same-rd ordering is the hazard unit's job, using pend_valid/pend_rd.
REQ-027 Data SHALL pass unmodified; no extension or truncation.

Reset
REQ-028 On rst: all entries empty, pend_valid = 0, pend_rd = 0, ptr = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0.
REQ-029 src_ready SHALL be 0 while rst is high and SHALL be 1 for all sources in the first cycle after release.
REQ-030 rst asserted mid-operation SHALL discard all held results without any rf_we pulse.

Structure
REQ-031 RADDR_W default, DATA_WIDTH default and the WB source index constants (SRC_ALU = 0, SRC_MEM = 1, SRC_LONG = 2) SHALL live in the shared defines header.
REQ-032 Arbitration SHALL be a sub-module rr_arbiter (parameter N; inputs req, advance; outputs one-hot grant, grant_valid), reusable by other arbiters.
REQ-033 The existing wb_sel result multiplexing stays upstream of this block; this block sees only final per-source results.

Verification
REQ-034 Single source: src 0 sends rd = 5, data = 0xDEADBEEF, we = 1 at edge 1 -> rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF after edge 2 only.
REQ-035 All 3 sources valid every cycle, ptr = 0 -> grants 0,1,2,0,1,2; each src_ready high every third cycle; rf_we high every cycle.
REQ-036 src 1 sends rd = 0, we = 1 -> entry consumed and src_ready[1] returns to 1; rf_we stays 0.
REQ-037 Entries 0 and 2 full, flush pulsed one cycle -> pend_valid = 0 next cycle, no rf_we, incoming transfer that cycle refused; ptr unchanged.
REQ-038 rst asserted asynchronously between edges with 2 entries full -> outputs zero immediately, no write after release.
REQ-039 Random stimulus with scoreboard -> every accepted we = 1, rd != 0 result appears exactly once on rf_*, per-source order preserved, no source starved beyond NUM_SRC cycles.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared writeback defines: default register-file geometry, the writeback
// source index assignments, and a small wrap-around increment helper used by
// round-robin pointers.
// ----------------------------------------------------------------------------
package wb_arbiter_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_RADDR_W    = 5;

  // Writeback producer slots on the arbiter source ports.
  localparam int SRC_ALU  = 0;
  localparam int SRC_MEM  = 1;
  localparam int SRC_LONG = 2;

  // (i + 1) mod n for 0 <= i < n, without a divider.
  function automatic int rr_wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Generic N-way round-robin arbiter. The search for a requester starts at the
// internal pointer and wraps. The pointer moves past the winner only when
// 'advance' is high, so a caller can issue a grant that is later discarded
// (e.g. on a flush) without disturbing fairness.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset (pointer -> 0)
//   req[N]       request vector
//   advance      commit this cycle's grant to the pointer
//   grant[N]     one-hot grant (all zero when nothing requests)
//   grant_valid  a grant is issued this cycle
// ----------------------------------------------------------------------------
module rr_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic         grant_valid
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gidx;
  logic [PW-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    gidx        = ptr_q;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_valid = 1'b1;
        gidx        = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_valid) begin
      ptr_d = PW'(rr_wrap_inc(int'(gidx), N));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// ----------------------------------------------------------------------------
// wb_arbiter
// Merges NUM_SRC writeback producers into the single register-file write
// port. Each source owns one holding entry {data, rd, we}; one occupied entry
// is granted per cycle in round-robin order and drives the registered rf_*
// outputs on the same edge that releases it.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   src_valid/src_ready      per-source valid/ready handshake
//   src_data, src_rd, src_we packed per-source result, dest index, write intent
//   flush                    synchronous kill: clears entries, blocks writes
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   pend_valid, pend_rd      occupancy and held rd per entry (hazard unit)
// ----------------------------------------------------------------------------
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int NUM_SRC    = 3,
  parameter int RADDR_W    = WB_RADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC*RADDR_W-1:0]    src_rd,
  input  logic [NUM_SRC-1:0]            src_we,
  input  logic                          flush,
  output logic                          rf_we,
  output logic [RADDR_W-1:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0]         rf_wdata,
  output logic [NUM_SRC-1:0]            pend_valid,
  output logic [NUM_SRC*RADDR_W-1:0]    pend_rd
);

  logic [NUM_SRC-1:0]    ent_vld_q, ent_vld_d;
  logic [NUM_SRC-1:0]    ent_we_q, ent_we_d;
  logic [DATA_WIDTH-1:0] ent_data_q [NUM_SRC];
  logic [DATA_WIDTH-1:0] ent_data_d [NUM_SRC];
  logic [RADDR_W-1:0]    ent_rd_q   [NUM_SRC];
  logic [RADDR_W-1:0]    ent_rd_d   [NUM_SRC];

  logic                  rf_we_q, rf_we_d;
  logic [RADDR_W-1:0]    rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic [NUM_SRC-1:0]    grant;
  logic                  grant_valid;
  logic [NUM_SRC-1:0]    fire;

  logic                  sel_we;
  logic [RADDR_W-1:0]    sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  // A grant issued during a flush is thrown away, so it must not move the
  // round-robin pointer either.
  rr_arbiter #(
    .N (NUM_SRC)
  ) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         (ent_vld_q),
    .advance     (!flush),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // An entry being drained this cycle can accept its successor on the same
  // edge, giving one transfer per cycle per source.
  assign src_ready = (rst || flush) ? '0 : (~ent_vld_q | grant);
  assign fire      = src_valid & src_ready;

  always_comb begin
    ent_vld_d = ent_vld_q;
    ent_we_d  = ent_we_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      ent_data_d[i] = ent_data_q[i];
      ent_rd_d[i]   = ent_rd_q[i];
      if (flush) begin
        ent_vld_d[i] = 1'b0;
      end else if (fire[i]) begin
        ent_vld_d[i]  = 1'b1;
        ent_we_d[i]   = src_we[i];
        ent_data_d[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        ent_rd_d[i]   = src_rd[i*RADDR_W +: RADDR_W];
      end else if (grant[i]) begin
        ent_vld_d[i] = 1'b0;
      end
    end
  end

  // One-hot grant makes an OR-reduction a valid mux.
  always_comb begin
    sel_we   = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_we   = sel_we | ent_we_q[i];
        sel_rd   = sel_rd | ent_rd_q[i];
        sel_data = sel_data | ent_data_q[i];
      end
    end
  end

  // Writes to x0 and no-write results are still consumed, just silently.
  always_comb begin
    rf_we_d    = grant_valid && sel_we && (sel_rd != '0) && !flush;
    rf_waddr_d = rf_we_d ? sel_rd   : rf_waddr_q;
    rf_wdata_d = rf_we_d ? sel_data : rf_wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld_q  <= '0;
      ent_we_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      ent_vld_q  <= ent_vld_d;
      ent_we_q   <= ent_we_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Payload is only meaningful while its valid bit is set; no reset needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      ent_data_q[i] <= ent_data_d[i];
      ent_rd_q[i]   <= ent_rd_d[i];
    end
  end

  always_comb begin
    pend_rd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pend_rd[i*RADDR_W +: RADDR_W] = ent_vld_q[i] ? ent_rd_q[i] : '0;
    end
  end

  assign pend_valid = ent_vld_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

endmodule
